picorv32_mem_responder: RTL and testbench

Wait-state-inserting memory model driving the PicoRV32 native memory port (mem_valid/mem_ready handshake) in formal and simulation harnesses. It is the downstream consumer of the core's memory requests. It holds a DEPTH-word byte-writable RAM and accepts each request after a bounded, externally steered number of stall cycles. It also flags violations of the request-stability protocol, so harness restrictions can be driven from its outputs.

---
 rtl/picorv32_mem_responder_if.sv | 20 ++
 rtl/picorv32_mem_responder.sv | 126 ++++++++++++
 tb/tb_picorv32_mem_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_mem_responder_if.sv
// PicoRV32 native memory port: the core drives the request, the responder answers.
interface picorv32_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Wait-state memory model for the PicoRV32 native port: byte-writable RAM, steerable
// stall insertion and a sticky request-stability checker.
module picorv32_mem_responder #(
  parameter int DEPTH     = 256,
  parameter int MAX_WAIT  = 4,
  parameter bit ZERO_INIT = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stall,
  picorv32_mem_responder_if.slave  bus,
  output logic                     busy,
  output logic [3:0]               wait_cnt,
  output logic                     proto_err
);

  localparam int       AW   = $clog2(DEPTH);
  localparam logic [3:0] MAXW = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        req_instr_q, req_instr_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        proto_err_q, proto_err_d;
  logic        ram_we;
  logic        can_stall;
  logic        viol;
  logic [AW-1:0] idx;

  // Not cleared by reset; ZERO_INIT=0 leaves the contents unknown.
  logic [31:0] ram [DEPTH] = '{default: (ZERO_INIT ? 32'h0 : 32'hx)};

  assign idx       = req_addr_q[AW+1:2];
  assign can_stall = stall && (wait_cnt_q < MAXW);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.mem_valid) state_d = WAIT;
      WAIT:    if (!can_stall) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_instr_d = req_instr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    wait_cnt_d  = wait_cnt_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    ram_we      = 1'b0;
    viol        = 1'b0;
    case (state_q)
      IDLE: if (bus.mem_valid) begin
        req_instr_d = bus.mem_instr;
        req_addr_d  = bus.mem_addr;
        req_wdata_d = bus.mem_wdata;
        req_wstrb_d = bus.mem_wstrb;
        wait_cnt_d  = 4'd0;
      end
      WAIT: if (can_stall) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end else begin
        ready_d = 1'b1;
        ram_we  = |req_wstrb_q;
        rdata_d = (|req_wstrb_q) ? 32'h0 : ram[idx];
      end
      default: ;
    endcase
    // The core must hold its request stable until it has seen mem_ready.
    if (state_q != IDLE)
      viol = !bus.mem_valid || (bus.mem_addr != req_addr_q) ||
             (bus.mem_wdata != req_wdata_q) || (bus.mem_wstrb != req_wstrb_q) ||
             (bus.mem_instr != req_instr_q);
    proto_err_d = proto_err_q | viol;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_instr_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      wait_cnt_q  <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      req_instr_q <= req_instr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      wait_cnt_q  <= wait_cnt_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (req_wstrb_q[i]) ram[idx][8*i +: 8] <= req_wdata_q[8*i +: 8];
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign busy          = (state_q != IDLE);
  assign wait_cnt      = wait_cnt_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Scoreboarded bench for picorv32_mem_responder: latency, byte lanes, wrap, stalls,
// back-to-back, protocol flag and reset behaviour.
module tb_picorv32_mem_responder;
  localparam int DEPTH    = 64;
  localparam int MAX_WAIT = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       busy;
  logic [3:0] wait_cnt;
  logic       proto_err;

  picorv32_mem_responder_if bus ();

  picorv32_mem_responder #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .ZERO_INIT(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .bus       (bus.slave),
    .busy      (busy),
    .wait_cnt  (wait_cnt),
    .proto_err (proto_err)
  );

  always #5 clock = ~clock;

  int cyc_no = 0;
  always @(posedge clock) cyc_no <= cyc_no + 1;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  wcnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          n_chk = 0;
  int          n_pass = 0;
  int          last_ready_cyc = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, stall for nst WAIT cycles, compare the response against the scoreboard.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int nst, input bit glitch, input bit hold);
    exp_t e;
    int   i = int'((a >> 2) % DEPTH);
    int   s = (nst > MAX_WAIT) ? MAX_WAIT : nst;
    int   cyc = 0;
    bit   got = 0;
    e.lat  = 2 + s;
    e.wcnt = 4'(s);
    if (ws == 4'b0) e.rdata = model[i];
    else begin
      e.rdata = 32'h0;
      for (int b = 0; b < 4; b++) if (ws[b]) model[i][8*b +: 8] = wd[8*b +: 8];
    end
    sb.push_back(e);
    bus.mem_valid = 1'b1;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    stall = 1'b0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (bus.mem_ready) got = 1;
      else begin
        n_chk++;
        if (busy !== 1'b1) $display("FAIL busy_in_wait addr=%h cyc=%0d got=%b want=1", a, cyc, busy);
        else n_pass++;
        stall = (cyc - 1 < nst);
        if (glitch && cyc == 1) bus.mem_addr = a ^ 32'h4;
        if (glitch && cyc == 2) begin
          n_chk++;
          if (proto_err !== 1'b1) $display("FAIL proto_err_next_cycle got=%b want=1", proto_err);
          else n_pass++;
        end
      end
    end
    e = sb.pop_front();
    n_chk++;
    if (!got) $display("FAIL ready_timeout addr=%h got=none want=ready within 40 cycles", a);
    else n_pass++;
    n_chk++;
    if (cyc != e.lat) $display("FAIL latency addr=%h got=%0d want=%0d", a, cyc, e.lat);
    else n_pass++;
    n_chk++;
    if (bus.mem_rdata !== e.rdata) $display("FAIL rdata addr=%h got=%h want=%h", a, bus.mem_rdata, e.rdata);
    else n_pass++;
    n_chk++;
    if (wait_cnt !== e.wcnt) $display("FAIL wait_cnt addr=%h got=%0d want=%0d", a, wait_cnt, e.wcnt);
    else n_pass++;
    last_ready_cyc = cyc_no;
    stall = 1'b0;
    tick();
    n_chk++;
    if (bus.mem_ready !== 1'b0) $display("FAIL ready_one_cycle addr=%h got=%b want=0", a, bus.mem_ready);
    else n_pass++;
    if (!hold) bus.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++;
    if ({bus.mem_ready, busy, proto_err} !== 3'b000)
      $display("FAIL reset_flags got=%b want=000", {bus.mem_ready, busy, proto_err});
    else n_pass++;
    n_chk++;
    if (bus.mem_rdata !== 32'h0 || wait_cnt !== 4'd0)
      $display("FAIL reset_data got=%h/%0d want=0/0", bus.mem_rdata, wait_cnt);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_latency();
    do_txn(32'h10, 32'h0, 4'b0, 0, 0, 0);
    tick();
  endtask

  task automatic test_byte_write();
    do_txn(32'h40, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    do_txn(32'h40, 32'h0, 4'b0, 0, 0, 0);
    n_chk++;
    if (bus.mem_rdata !== 32'h00BB00DD) $display("FAIL byte_lanes got=%h want=00bb00dd", bus.mem_rdata);
    else n_pass++;
    do_txn(32'h40 + 4 * DEPTH, 32'h0, 4'b0, 0, 0, 0);
    n_chk++;
    if (bus.mem_rdata !== 32'h00BB00DD) $display("FAIL addr_wrap got=%h want=00bb00dd", bus.mem_rdata);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_txn(32'h40, 32'h0, 4'b0, 20, 0, 0);
    do_txn(32'h40, 32'h0, 4'b0, 2, 0, 0);
    do_txn(32'h44, 32'hDEADBEEF, 4'b1111, 3, 0, 0);
  endtask

  task automatic test_back_to_back();
    int r1;
    do_txn(32'h40, 32'h0, 4'b0, 0, 0, 1);
    r1 = last_ready_cyc;
    do_txn(32'h44, 32'h0, 4'b0, 0, 0, 0);
    n_chk++;
    if (last_ready_cyc - r1 != 3) $display("FAIL b2b_spacing got=%0d want=3", last_ready_cyc - r1);
    else n_pass++;
    n_chk++;
    if (proto_err !== 1'b0) $display("FAIL b2b_proto_err got=%b want=0", proto_err);
    else n_pass++;
  endtask

  task automatic test_proto();
    do_txn(32'h20, 32'h11112222, 4'b1111, 0, 0, 0);
    n_chk++;
    if (proto_err !== 1'b0) $display("FAIL proto_clean got=%b want=0", proto_err);
    else n_pass++;
    do_txn(32'h20, 32'h0, 4'b0, 2, 1, 0);
    n_chk++;
    if (bus.mem_rdata !== 32'h11112222) $display("FAIL proto_resp_word got=%h want=11112222", bus.mem_rdata);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if (proto_err !== 1'b1) $display("FAIL proto_sticky got=%b want=1", proto_err);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++;
    if (proto_err !== 1'b0) $display("FAIL proto_reset_clear got=%b want=0", proto_err);
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h80;
    bus.mem_wdata = 32'h12345678;
    bus.mem_wstrb = 4'b1111;
    stall = 1'b1;
    tick();
    tick();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL mid_busy_before got=%b want=1", busy);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({bus.mem_ready, busy, wait_cnt} !== 6'b0)
      $display("FAIL mid_reset_async got=%b want=000000", {bus.mem_ready, busy, wait_cnt});
    else n_pass++;
    bus.mem_valid = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_txn(32'h80, 32'h0, 4'b0, 0, 0, 0);
    n_chk++;
    if (bus.mem_rdata !== 32'h0) $display("FAIL mid_no_write got=%h want=0", bus.mem_rdata);
    else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) model[k] = 32'h0;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'b0;
    test_reset();
    test_read_latency();
    test_byte_write();
    test_stall();
    test_back_to_back();
    test_proto();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
